minute_tick_gen: RTL and testbench

- Parametrised successor of the fixed minute divider.
- Divides `clk` by a run-time-programmable period and emits a one-cycle `tick` plus a 50 % square wave.
- Counts elapsed ticks, with saturation.
- Tracks IDLE/RUN/HOLD state so waiting-time billing can pause and resume without losing the partial period.
- Sits between the clock input and the fee logic. The fee logic drives `max` back into it.

---
 rtl/minute_tick_gen.sv | 151 +++++++++++++++
 tb/tb_minute_tick_gen.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/minute_tick_gen.sv
// Programmable clock divider for the fare meter: one-cycle tick, 50 % square wave,
// saturating elapsed-tick count and IDLE/RUN/HOLD tracking for pausable waiting-time billing.
module minute_tick_gen #(
    parameter int unsigned        CNT_W      = 32,
    parameter logic [CNT_W-1:0]   DEF_PERIOD = 32'd3_000_000_000,
    parameter int unsigned        EL_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             max,
    input  logic             clr,
    input  logic             period_ld,
    input  logic [CNT_W-1:0] period_in,
    output logic             tick,
    output logic             sq,
    output logic [EL_W-1:0]  elapsed,
    output logic             elapsed_full,
    output logic [1:0]       state,
    output logic             load_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] per_act_q, per_act_d;
    logic [CNT_W-1:0] per_pend_q, per_pend_d;
    logic             pend_v_q, pend_v_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;
    logic [EL_W-1:0]  elapsed_q, elapsed_d;
    logic             elapsed_full_q, elapsed_full_d;
    logic             load_err_q, load_err_d;

    logic             run;
    logic             ld_ok;
    logic [CNT_W-1:0] reload_val;

    assign run   = en && !max;
    assign ld_ok = period_ld && (period_in != '0);

    // A fresh strobe beats a pending value, which beats the active period.
    always_comb begin
        reload_val = per_act_q;
        if (pend_v_q) reload_val = per_pend_q;
        if (ld_ok)    reload_val = period_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (run)  state_d = RUN;
                RUN:     if (!run) state_d = HOLD;
                HOLD:    if (run)  state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        state = state_q;
    end

    always_comb begin
        cnt_d      = cnt_q;
        per_act_d  = per_act_q;
        per_pend_d = per_pend_q;
        pend_v_d   = pend_v_q;
        tick_d     = 1'b0;
        sq_d       = sq_q;
        elapsed_d  = elapsed_q;
        load_err_d = period_ld && (period_in == '0);

        if (clr) begin
            per_act_d = reload_val;
            cnt_d     = reload_val;
            pend_v_d  = 1'b0;
            sq_d      = 1'b0;
            elapsed_d = '0;
        end else if (ld_ok && state_q == IDLE) begin
            per_act_d = period_in;
            cnt_d     = period_in;
            pend_v_d  = 1'b0;
        end else begin
            if (ld_ok) begin
                per_pend_d = period_in;
                pend_v_d   = 1'b1;
            end
            if (run) begin
                if (cnt_q == CNT_W'(1)) begin
                    per_act_d = reload_val;
                    cnt_d     = reload_val;
                    pend_v_d  = 1'b0;
                    tick_d    = 1'b1;
                    sq_d      = 1'b0;
                    if (elapsed_q != '1) elapsed_d = elapsed_q + EL_W'(1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_d == (per_act_q >> 1)) sq_d = 1'b1;
                end
            end
        end

        elapsed_full_d = (elapsed_d == '1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q          <= DEF_PERIOD;
            per_act_q      <= DEF_PERIOD;
            per_pend_q     <= DEF_PERIOD;
            pend_v_q       <= 1'b0;
            tick_q         <= 1'b0;
            sq_q           <= 1'b0;
            elapsed_q      <= '0;
            elapsed_full_q <= 1'b0;
            load_err_q     <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            per_act_q      <= per_act_d;
            per_pend_q     <= per_pend_d;
            pend_v_q       <= pend_v_d;
            tick_q         <= tick_d;
            sq_q           <= sq_d;
            elapsed_q      <= elapsed_d;
            elapsed_full_q <= elapsed_full_d;
            load_err_q     <= load_err_d;
        end
    end

    assign tick         = tick_q;
    assign sq           = sq_q;
    assign elapsed      = elapsed_q;
    assign elapsed_full = elapsed_full_q;
    assign load_err     = load_err_q;

endmodule

// File: tb/tb_minute_tick_gen.sv
// Directed bench for minute_tick_gen: expected ticks (edge index, elapsed, full) are queued
// by the stimulus and consumed by a monitor whenever the DUT raises tick.
module tb_minute_tick_gen;

    localparam int unsigned CNT_W = 32;
    localparam int unsigned EL_W  = 2;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             max;
    logic             clr;
    logic             period_ld;
    logic [CNT_W-1:0] period_in;
    logic             tick;
    logic             sq;
    logic [EL_W-1:0]  elapsed;
    logic             elapsed_full;
    logic [1:0]       state;
    logic             load_err;

    minute_tick_gen #(
        .CNT_W      (CNT_W),
        .DEF_PERIOD (32'd5),
        .EL_W       (EL_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .max          (max),
        .clr          (clr),
        .period_ld    (period_ld),
        .period_in    (period_in),
        .tick         (tick),
        .sq           (sq),
        .elapsed      (elapsed),
        .elapsed_full (elapsed_full),
        .state        (state),
        .load_err     (load_err)
    );

    typedef struct {
        int     e;
        int     el;
        bit     full;
    } exp_t;

    exp_t exp_q[$];
    int   edge_n = 0;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   base;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic push(input int e, input int el, input bit full);
        exp_t x;
        x.e = e;
        x.el = el;
        x.full = full;
        exp_q.push_back(x);
    endtask

    // Monitor: every tick must match the oldest queued expectation.
    always @(negedge clk) begin
        if (tick === 1'b1) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_tick: tick at edge %0d, elapsed %0d, none expected", edge_n, elapsed);
            end else begin
                exp_t x;
                x = exp_q.pop_front();
                if (edge_n != x.e || int'(elapsed) != x.el || elapsed_full !== x.full) begin
                    n_fail++;
                    $display("FAIL tick: got edge %0d elapsed %0d full %0b expected edge %0d elapsed %0d full %0b",
                             edge_n, elapsed, elapsed_full, x.e, x.el, x.full);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; max = 1'b0; clr = 1'b0; period_ld = 1'b0; period_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_tick", tick, 0);
        chk("rst_sq", sq, 0);
        chk("rst_elapsed", elapsed, 0);
        chk("rst_full", elapsed_full, 0);
        chk("rst_state", state, 0);
        chk("rst_load_err", load_err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Free run at the default period 5, five periods with EL_W=2 saturation
        en = 1'b1;
        base = edge_n + 1;
        for (int k = 1; k <= 5; k++) push(base + 5 * k - 1, (k > 3) ? 3 : k, k >= 3);
        for (int j = 0; j < 25; j++) begin
            @(negedge clk);
            chk("sq_free_run", sq, ((j % 5) == 2 || (j % 5) == 3) ? 1 : 0);
            if (j == 0) chk("state_run", state, 1);
        end
        en = 1'b0; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_state", state, 0);
        chk("clr_elapsed", elapsed, 0);
        chk("clr_full", elapsed_full, 0);
        chk("clr_sq", sq, 0);

        // Enable stall for 4 cycles after 2 counts, then max stall at cnt==1
        en = 1'b1;
        base = edge_n + 1;
        push(base + 8, 1, 0);
        push(base + 16, 2, 0);
        push(base + 21, 3, 1);
        repeat (2) @(negedge clk);
        chk("hold_pre_state", state, 1);
        en = 1'b0;
        @(negedge clk);
        chk("hold_state", state, 2);
        repeat (3) @(negedge clk);
        chk("hold_sq", sq, 0);
        chk("hold_state_end", state, 2);
        en = 1'b1;
        @(negedge clk);
        chk("resume_sq", sq, 1);
        chk("resume_state", state, 1);
        repeat (6) @(negedge clk);
        max = 1'b1;
        @(negedge clk);
        chk("max_state", state, 2);
        repeat (2) @(negedge clk);
        max = 1'b0;
        repeat (6) @(negedge clk);
        en = 1'b0; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;

        // Pending period load mid-period, then a rejected zero load
        en = 1'b1;
        base = edge_n + 1;
        push(base + 4, 1, 0);
        push(base + 7, 2, 0);
        push(base + 10, 3, 1);
        push(base + 13, 3, 1);
        push(base + 16, 3, 1);
        repeat (2) @(negedge clk);
        period_ld = 1'b1; period_in = 32'd3;
        @(negedge clk);
        period_ld = 1'b0;
        chk("load_ok_err", load_err, 0);
        repeat (8) @(negedge clk);
        period_ld = 1'b1; period_in = '0;
        @(negedge clk);
        period_ld = 1'b0;
        chk("load_zero_err", load_err, 1);
        @(negedge clk);
        chk("load_err_pulse", load_err, 0);
        repeat (6) @(negedge clk);
        chk("pre_clr_sq", sq, 1);

        // clr on the reload edge wins over the tick
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_reload_tick", tick, 0);
        chk("clr_reload_elapsed", elapsed, 0);
        chk("clr_reload_state", state, 0);
        chk("clr_reload_sq", sq, 0);

        // Async reset mid-period
        base = edge_n + 1;
        push(base + 2, 1, 0);
        repeat (5) @(negedge clk);
        chk("pre_rst_sq", sq, 1);
        chk("pre_rst_elapsed", elapsed, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_sq", sq, 0);
        chk("async_rst_elapsed", elapsed, 0);
        chk("async_rst_state", state, 0);
        chk("async_rst_tick", tick, 0);
        @(negedge clk);
        rst_n = 1'b1;
        base = edge_n + 1;
        push(base + 4, 1, 0);
        repeat (7) @(negedge clk);

        chk("missing_ticks", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
